vec_alu_pipe: RTL and testbench
===============================

Name: vec_alu_pipe

Overview:
- Pipelined, parametrised vector ALU for the vector datapath; the next generation of the combinational 16x32 add/multiply ALU.
- Generalised in lane count, lane width, operation set and latency; adds a valid/ready handshake with backpressure.
- Each lane produces a double-width result split into a low word and a high word.
- Sits between the vector register-file read port and the write-back stage.

Parameters:
- LANES, 16, number of independent lanes.
- WIDTH, 32, bits per lane operand.
- LAT, 3, pipeline latency in cycles from accept to result (legal range 1..8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- op  in  2  operation: 00 add, 01 signed mul, 10 sub, 11 unsigned mul.
- a  in  LANES*WIDTH  operand vector A; lane i at [WIDTH*i +: WIDTH].
- b  in  LANES*WIDTH  operand vector B; same packing as a.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- res_lo  out  LANES*WIDTH  low word per lane.
- res_hi  out  LANES*WIDTH  high word per lane.

Behaviour:
- Reset (rst_n low at a clock edge):
  - All stage valid bits clear; out_valid=0.
  - res_lo and res_hi = 0; all pipeline data registers = 0.
  - Reset mid-operation discards every in-flight bundle; no partial result is ever presented.
- Pipeline control:
  - LAT stages, each with a valid bit and a data register.
  - Global advance enable: en = !out_valid | out_ready.
  - in_ready = en; in_ready is combinational from out_valid/out_ready only, never from in_valid.
  - Accept happens when in_valid & in_ready.
  - When en=1, every stage shifts forward and stage 0 loads the accepted bundle (valid=in_valid).
  - When en=0, all stages hold, and out_valid, res_lo and res_hi stay stable.
- Latency and throughput:
  - A bundle accepted at edge t appears with out_valid=1 after edge t+LAT-1, assuming no stalls.
  - Each stall cycle adds exactly one cycle.
  - Throughput is 1 bundle per cycle when out_ready is held high.
- Ordering: results leave in acceptance order; no reordering, loss or duplication.
- Simultaneous accept and drain in the same cycle is legal: the pipeline stays full with no bubble.
- Arithmetic (per lane, computed in stage 0, carried through the remaining stages):
  - add: s = sext(a)+sext(b) at WIDTH+1 bits; res_lo = s[WIDTH-1:0]; res_hi = all bits = s[WIDTH] (sign replicate).
  - sub: s = sext(a)-sext(b) at WIDTH+1 bits; same split as add.
  - signed mul: p = signed a*b at 2*WIDTH bits; res_lo = p[WIDTH-1:0]; res_hi = p[2*WIDTH-1:WIDTH].
  - unsigned mul: same split as signed mul, with operands zero-extended.
  - Lanes are fully independent; there is no inter-lane carry.
- op is sampled only on accept and travels with the bundle, so mixed ops back-to-back are legal.
- With LAT=1 the result register is the only stage.

Optional Feature:
- Macro: VEC_ALU_OVF_EN.
- When defined:
  - Extra output ovf, LANES bits, reset 0, aligned and stalled with res_lo.
  - ovf[i]=1 when lane i's full result does not fit in WIDTH bits under the op's signedness.
  - add/sub: s[WIDTH] != s[WIDTH-1].
  - signed mul: p[2*WIDTH-1:WIDTH-1] is not all-equal.
  - unsigned mul: p[2*WIDTH-1:WIDTH] != 0.
- When undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, then rst_n=1 with in_valid=0.
  - Required: out_valid=0, res_lo=res_hi=0, in_ready=1.
- Signed add with carry-out sign:
  - Stimulus: lane0 a=0x7FFFFFFF, b=0x00000001, op=00, LAT=3.
  - Required: after 3 edges, res_lo lane0=0x80000000, res_hi lane0=0x00000000; ovf[0]=1 when VEC_ALU_OVF_EN is defined.
- Signed vs unsigned mul:
  - Stimulus: a=0xFFFFFFFF, b=0x00000002, issued back-to-back as op=01 then op=11.
  - Required: first result lo=0xFFFFFFFE, hi=0xFFFFFFFF; second result lo=0xFFFFFFFE, hi=0x00000001; results on consecutive cycles.
- Backpressure:
  - Stimulus: stream 5 bundles with lane0 a=1..5, b=0, op=00; hold out_ready=0 for 4 cycles once out_valid rises.
  - Required: in_ready=0 during the hold; res_lo held stable; outputs 1,2,3,4,5 in order with no loss or duplication.
- Reset mid-operation:
  - Stimulus: 3 bundles in flight, then rst_n=0 for 1 cycle.
  - Required: next cycle out_valid=0 and data=0; no stale result appears in the following LAT cycles.
- Lane independence:
  - Stimulus: LANES=4, WIDTH=8, op=10, lane i a=i, b=3.
  - Required: res_lo lanes = 0xFD, 0xFE, 0xFF, 0x00; res_hi lanes = 0xFF, 0xFF, 0xFF, 0x00.

Source files
------------

// File: rtl/vec_alu_pipe.sv
// Pipelined vector ALU: per-lane add/sub/signed mul/unsigned mul with double-width results.
// Optional per-lane overflow flags when VEC_ALU_OVF_EN is defined.
module vec_alu_pipe #(
  parameter int LANES = 16,
  parameter int WIDTH = 32,
  parameter int LAT   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] res_lo,
  output logic [LANES*WIDTH-1:0] res_hi
`ifdef VEC_ALU_OVF_EN
  ,
  output logic [LANES-1:0]       ovf
`endif
);

  localparam int VW = LANES * WIDTH;

  logic           en;
  wire  [VW-1:0]  lo_d;
  wire  [VW-1:0]  hi_d;
  logic [LAT-1:0] vld;
  logic [VW-1:0]  lo_q [LAT];
  logic [VW-1:0]  hi_q [LAT];
`ifdef VEC_ALU_OVF_EN
  wire  [LANES-1:0] ovf_d;
  logic [LANES-1:0] ovf_q [LAT];
`endif

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0]   la, lb;
    logic [WIDTH:0]     sum, dif;
    logic [2*WIDTH-1:0] ps, pu;

    assign la  = a[WIDTH*i +: WIDTH];
    assign lb  = b[WIDTH*i +: WIDTH];
    assign sum = {la[WIDTH-1], la} + {lb[WIDTH-1], lb};
    assign dif = {la[WIDTH-1], la} - {lb[WIDTH-1], lb};
    // 2W x 2W truncated to 2W bits gives the exact signed product of the sign-extended operands.
    assign ps  = {{WIDTH{la[WIDTH-1]}}, la} * {{WIDTH{lb[WIDTH-1]}}, lb};
    assign pu  = {{WIDTH{1'b0}}, la} * {{WIDTH{1'b0}}, lb};

    assign lo_d[WIDTH*i +: WIDTH] = op[0] ? (op[1] ? pu[WIDTH-1:0] : ps[WIDTH-1:0])
                                          : (op[1] ? dif[WIDTH-1:0] : sum[WIDTH-1:0]);
    assign hi_d[WIDTH*i +: WIDTH] = op[0] ? (op[1] ? pu[2*WIDTH-1:WIDTH] : ps[2*WIDTH-1:WIDTH])
                                          : {WIDTH{op[1] ? dif[WIDTH] : sum[WIDTH]}};
`ifdef VEC_ALU_OVF_EN
    assign ovf_d[i] = op[0] ? (op[1] ? (|pu[2*WIDTH-1:WIDTH])
                                     : !((&ps[2*WIDTH-1:WIDTH-1]) || !(|ps[2*WIDTH-1:WIDTH-1])))
                            : (op[1] ? (dif[WIDTH] ^ dif[WIDTH-1]) : (sum[WIDTH] ^ sum[WIDTH-1]));
`endif
  end

  // Bubbles carry zero data so an idle output never shows stale operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < LAT; k++) begin
        lo_q[k] <= '0;
        hi_q[k] <= '0;
`ifdef VEC_ALU_OVF_EN
        ovf_q[k] <= '0;
`endif
      end
    end else if (en) begin
      vld[0]  <= in_valid;
      lo_q[0] <= in_valid ? lo_d : '0;
      hi_q[0] <= in_valid ? hi_d : '0;
`ifdef VEC_ALU_OVF_EN
      ovf_q[0] <= in_valid ? ovf_d : '0;
`endif
      for (int k = 1; k < LAT; k++) begin
        vld[k]  <= vld[k-1];
        lo_q[k] <= lo_q[k-1];
        hi_q[k] <= hi_q[k-1];
`ifdef VEC_ALU_OVF_EN
        ovf_q[k] <= ovf_q[k-1];
`endif
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign res_lo    = lo_q[LAT-1];
  assign res_hi    = hi_q[LAT-1];
`ifdef VEC_ALU_OVF_EN
  assign ovf       = ovf_q[LAT-1];
`endif

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Bench for vec_alu_pipe: directed corner cases plus randomized traffic against a
// queue-based arithmetic reference model; a second small instance covers LAT=1 and 8-bit lanes.
module tb_vec_alu_pipe;
  localparam int LANES = 16;
  localparam int W     = 32;
  localparam int LAT   = 3;
  localparam int VW    = LANES * W;
  localparam int SL    = 4;
  localparam int SW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = '0;
  logic [VW-1:0] a = '0;
  logic [VW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] res_lo;
  logic [VW-1:0] res_hi;
`ifdef VEC_ALU_OVF_EN
  logic [LANES-1:0] ovf;
  logic [SL-1:0]    s_ovf;
`endif

  logic             s_in_valid = 1'b0;
  logic             s_in_ready;
  logic [1:0]       s_op = '0;
  logic [SL*SW-1:0] s_a = '0;
  logic [SL*SW-1:0] s_b = '0;
  logic             s_out_valid;
  logic             s_out_ready = 1'b1;
  logic [SL*SW-1:0] s_res_lo;
  logic [SL*SW-1:0] s_res_hi;

  always #5 clk = ~clk;

  vec_alu_pipe #(.LANES(LANES), .WIDTH(W), .LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res_lo(res_lo), .res_hi(res_hi)
`ifdef VEC_ALU_OVF_EN
    , .ovf(ovf)
`endif
  );

  vec_alu_pipe #(.LANES(SL), .WIDTH(SW), .LAT(1)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
    .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .res_lo(s_res_lo), .res_hi(s_res_hi)
`ifdef VEC_ALU_OVF_EN
    , .ovf(s_ovf)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [VW-1:0]    lo;
    logic [VW-1:0]    hi;
    logic [LANES-1:0] ov;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: true mathematical result in 64 bits, then split and range-checked.
  function automatic void model_lane(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] lo, output logic [W-1:0] hi, output logic ov);
    longint sx, sy, r;
    logic [63:0] u;
    sx = $signed(x);
    sy = $signed(y);
    if (o == 2'b11) begin
      u  = {32'b0, x} * {32'b0, y};
      lo = u[31:0];
      hi = u[63:32];
      ov = (hi != 0);
    end else begin
      case (o)
        2'b00:   r = sx + sy;
        2'b10:   r = sx - sy;
        default: r = sx * sy;
      endcase
      u  = r;
      lo = u[31:0];
      hi = (o == 2'b01) ? u[63:32] : ((r < 0) ? 32'hFFFF_FFFF : 32'h0);
      ov = (r < -64'sd2147483648) || (r > 64'sd2147483647);
    end
  endfunction

  function automatic exp_t model_vec(input logic [1:0] o, input logic [VW-1:0] x, input logic [VW-1:0] y);
    exp_t e;
    logic [W-1:0] lo, hi;
    logic ov;
    for (int i = 0; i < LANES; i++) begin
      model_lane(o, x[W*i +: W], y[W*i +: W], lo, hi, ov);
      e.lo[W*i +: W] = lo;
      e.hi[W*i +: W] = hi;
      e.ov[i]        = ov;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, sent, got, hold;
    bit started, stalled_prev;
    logic [VW-1:0] prev_lo, prev_hi;
    exp_t e;

    // Reset then idle
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res_lo", res_lo, 0);
    chk("rst_res_hi", res_hi, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_small_valid", s_out_valid, 0);

    // Signed add overflowing into the sign bit
    op = 2'b00; a = '0; b = '0;
    a[W-1:0] = 32'h7FFF_FFFF; b[W-1:0] = 32'h0000_0001;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); n = 1;
    @(negedge clk); in_valid = 1'b0;
    while (!out_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    chk("add_latency", n, LAT);
    chk("add_lo", res_lo[W-1:0], 32'h8000_0000);
    chk("add_hi", res_hi[W-1:0], 32'h0000_0000);
`ifdef VEC_ALU_OVF_EN
    chk("add_ovf", ovf[0], 1);
`endif
    @(posedge clk); @(negedge clk);

    // Signed then unsigned multiply, back to back
    a = '0; b = '0;
    a[W-1:0] = 32'hFFFF_FFFF; b[W-1:0] = 32'h0000_0002;
    op = 2'b01; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    op = 2'b11;
    @(posedge clk); n = 2;
    @(negedge clk); in_valid = 1'b0;
    while (!out_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    chk("mul_latency", n, LAT);
    chk("smul_lo", res_lo[W-1:0], 32'hFFFF_FFFE);
    chk("smul_hi", res_hi[W-1:0], 32'hFFFF_FFFF);
    @(posedge clk); @(negedge clk);
    chk("umul_valid", out_valid, 1);
    chk("umul_lo", res_lo[W-1:0], 32'hFFFF_FFFE);
    chk("umul_hi", res_hi[W-1:0], 32'h0000_0001);
`ifdef VEC_ALU_OVF_EN
    chk("umul_ovf", ovf[0], 1);
`endif
    @(posedge clk); @(negedge clk);
    chk("mul_no_dup", out_valid, 0);

    // Backpressure: 4-cycle hold once the first result shows
    sent = 0; got = 0; hold = 0; started = 0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      if (!started && out_valid) begin started = 1; hold = 4; end
      out_ready = (hold == 0);
      in_valid  = (sent < 5);
      op = 2'b00; a = '0; b = '0;
      a[W-1:0] = sent + 1;
      #1;
      if (hold > 0) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_lo", res_lo[W-1:0], 1);
        hold--;
      end
      if (out_valid && out_ready) begin
        chk("bp_order", res_lo[W-1:0], got + 1);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); @(negedge clk);
    end
    chk("bp_count", got, 5);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_no_dup", out_valid, 0);

    // Reset with three bundles in flight
    out_ready = 1'b0; op = 2'b00;
    for (int k = 0; k < 3; k++) begin
      a = '0; b = '0; a[W-1:0] = 100 + k;
      in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_lo", res_lo, 0);
    chk("mrst_hi", res_hi, 0);
    for (int k = 0; k < LAT + 1; k++) begin
      @(posedge clk); @(negedge clk);
      chk("mrst_no_stale", out_valid, 0);
    end

    // Lane independence on the 4x8, LAT=1 instance
    s_op = 2'b10;
    s_a  = {8'd3, 8'd2, 8'd1, 8'd0};
    s_b  = {8'd3, 8'd3, 8'd3, 8'd3};
    s_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    s_in_valid = 1'b0;
    chk("lane_valid", s_out_valid, 1);
    chk("lane_lo", s_res_lo, 32'h00FF_FEFD);
    chk("lane_hi", s_res_hi, 32'h00FF_FFFF);
`ifdef VEC_ALU_OVF_EN
    chk("lane_ovf", s_ovf, 0);
`endif
    @(posedge clk); @(negedge clk);
    chk("lane_drained", s_out_valid, 0);

    // Randomized traffic with random backpressure
    stalled_prev = 0; prev_lo = '0; prev_hi = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = 2'($urandom_range(0, 3));
      for (int i = 0; i < LANES; i++) begin
        a[W*i +: W] = rnd_word();
        b[W*i +: W] = rnd_word();
      end
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      chk("rnd_in_ready", in_ready, !out_valid || out_ready);
      if (stalled_prev) begin
        chk("rnd_stall_valid", out_valid, 1);
        chk("rnd_stall_lo", res_lo, prev_lo);
        chk("rnd_stall_hi", res_hi, prev_hi);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("rnd_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rnd_lo", res_lo, e.lo);
          chk("rnd_hi", res_hi, e.hi);
`ifdef VEC_ALU_OVF_EN
          chk("rnd_ovf", ovf, e.ov);
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back(model_vec(op, a, b));
      stalled_prev = out_valid && !out_ready;
      prev_lo = res_lo;
      prev_hi = res_hi;
      @(posedge clk); @(negedge clk);
    end

    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && sb.size() > 0; cyc++) begin
      #1;
      if (out_valid) begin
        e = sb.pop_front();
        chk("drain_lo", res_lo, e.lo);
        chk("drain_hi", res_hi, e.hi);
`ifdef VEC_ALU_OVF_EN
        chk("drain_ovf", ovf, e.ov);
`endif
      end
      @(posedge clk); @(negedge clk);
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); @(negedge clk);
    chk("drain_idle", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
